// File: rtl/mmio_console_if.sv
// mmio_console_if: CPU data-bus slave port of the memory-mapped console.
// The CPU side (master) issues select/strobes/address/data; the console
// (slave) returns registered load data.
interface mmio_console_if;
    logic        sel;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output sel,
        output we,
        output re,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  sel,
        input  we,
        input  re,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console responder.
// Stores to TXDATA are queued in a circular TX FIFO and drained over an 8N1
// serial line; a store to EXIT raises a sticky halt flag with an exit code.
// Optional macro CONSOLE_SIM_PRINT_EN echoes accepted characters and EXIT
// writes to the simulator log; it has no effect on the ports.
module mmio_console #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    mmio_console_if.slave bus,
    output logic          tx,
    output logic          halt,
    output logic [7:0]    exit_code
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_idx;
    logic [BAUD_W-1:0] baud_cnt;
    logic              baud_done;
    logic [1:0]        reg_sel;
    logic              wr_en;
    logic              rd_en;
    logic              push_req;
    logic              status_wr;
    logic              exit_wr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              busy;
    logic [4:0]        count_ext;
    logic [3:0]        count_sat;
    logic [31:0]       status_word;
    logic              unused_bits;

    assign reg_sel    = bus.addr[3:2];
    assign wr_en      = bus.sel & bus.we;
    assign rd_en      = bus.sel & bus.re;
    assign push_req   = wr_en && (reg_sel == 2'd0);
    assign status_wr  = wr_en && (reg_sel == 2'd1);
    assign exit_wr    = wr_en && (reg_sel == 2'd2);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push       = push_req && (!fifo_full || pop);
    assign baud_done  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign busy       = (state != S_IDLE);
    assign count_ext  = 5'(count);
    assign count_sat  = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
    assign status_word = {24'b0, count_sat, overflow, busy, fifo_empty, fifo_full};
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.wdata[7:0];
    end

    // Sticky overflow flag: set on a dropped byte, cleared by STATUS write with bit 3
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (push_req && fifo_full && !pop)
            overflow <= 1'b1;
        else if (status_wr && bus.wdata[3])
            overflow <= 1'b0;
    end

    // Sticky halt request; later EXIT writes only replace the code
    always_ff @(posedge clk) begin
        if (reset) begin
            halt      <= 1'b0;
            exit_code <= 8'h00;
        end else if (exit_wr) begin
            halt      <= 1'b1;
            exit_code <= bus.wdata[7:0];
        end
    end

    // Registered load data reflecting state before the sampling edge; held between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rdata <= '0;
        end else if (rd_en) begin
            case (reg_sel)
                2'd1:    bus.rdata <= status_word;
                2'd2:    bus.rdata <= {23'b0, halt, exit_code};
                default: bus.rdata <= '0;
            endcase
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Baud counter, bit index and shift register; counter restarts at every bit boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == S_IDLE || baud_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + BAUD_W'(1);
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
                bit_idx   <= '0;
            end else if (state == S_DATA && baud_done) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    // Serializer next-state: start when data is queued, advance on bit boundaries
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (!fifo_empty) next_state = S_START;
            S_START: if (baud_done) next_state = S_DATA;
            S_DATA:  if (baud_done && bit_idx == 3'd7) next_state = S_STOP;
            S_STOP:  if (baud_done) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Serial line level: low start bit, LSB-first data, high stop and idle
    always_comb begin
        tx = 1'b1;
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

`ifdef CONSOLE_SIM_PRINT_EN
    // Echo accepted characters and exit requests to the simulation log
    always @(posedge clk) begin
        if (!reset && push)    $write("%c", bus.wdata[7:0]);
        if (!reset && exit_wr) $display("EXIT %0d", bus.wdata[7:0]);
    end
`else
    // Synthesizable build: no simulation echo logic.
`endif

endmodule

// File: doc/mmio_console.md
# mmio_console

Memory-mapped console responder on the CPU data bus: the CPU initiates loads/stores, this block answers them. Stores to TXDATA queue bytes in a small FIFO that drains over an 8N1 serial line. A store to EXIT raises a sticky `halt` flag with an exit code, which the top-level bench uses to end simulation. It sits beside data memory in `top`, selected by the external address decoder.

## Interface
- `CLKS_PER_BIT`, 4: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2 to 16.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  device selected by the external decoder; `we` and `re` are ignored when low.
- `we`  in  1  store strobe; one write per cycle with `we & sel`.
- `re`  in  1  load strobe.
- `addr`  in  4  byte offset; `addr[1:0]` is ignored.
- `wdata`  in  32  store data.
- `rdata`  out  32  load data, registered.
- `tx`  out  1  serial output; idles high.
- `halt`  out  1  sticky exit request.
- `exit_code`  out  8  code latched by the EXIT write.

## Operation
- Register map:
  - 0x0 TXDATA, write: push `wdata[7:0]`. Reads return 0.
  - 0x4 STATUS, read: bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow, bits[7:4] FIFO count (saturates at 15), other bits 0. Writing with `wdata[3]`=1 clears overflow; other bits are ignored.
  - 0x8 EXIT, write: `halt`<=1 and `exit_code`<=`wdata[7:0]`. Reads return `{23'b0, halt, exit_code}`.
  - 0xC: reads return 0; writes are ignored.
- The FIFO is a circular buffer with wrapping read/write pointers and a count.
- Push when full with no pop in the same cycle: the byte is dropped and overflow is set.
- Push and pop in the same cycle are both performed, including when full; the count is unchanged.
- Serializer FSM:
  - IDLE: `tx`=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each; a 3-bit index counts the bits.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- Bit timing comes from a baud counter that reloads on every state or bit change.
- tx_busy is 1 in any state other than IDLE.
- `halt` and `exit_code` are sticky. A second EXIT write overwrites `exit_code` and `halt` stays 1. Console output continues after halt.

## Timing
- Reset values: `rdata`=0, `tx`=1, `halt`=0, `exit_code`=0. FSM in IDLE, FIFO empty, overflow 0, counters 0.
- Reset mid-frame: `tx` goes to 1 at the next edge, and queued bytes are discarded.
- Read latency is 1 cycle: `re & sel` sampled at edge E gives `rdata` valid after E. `rdata` holds its value until the next read.
- STATUS reflects state before edge E. A write sampled at the same edge is not visible until the next read.
- Write sampled at edge E0: the FIFO holds the byte after E0. The FSM pops at E1, and `tx` falls after E1.
- A frame lasts exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: IDLE lasts one cycle between STOP and the next START.
- The stop bit is therefore high for `CLKS_PER_BIT`+1 cycles when the FIFO is not empty.
- `halt` rises in the cycle after the EXIT write edge.

## Configuration
- `CONSOLE_SIM_PRINT_EN` defined:
  - Each accepted TXDATA push prints its character with `$write`.
  - An EXIT write prints "EXIT <code>" via `$display`.
  - Simulation-only logic, with no effect on the ports.
- Not defined: no system tasks are compiled and the block is fully synthesizable. Port behaviour is identical either way.

## Test plan
- Reset: hold `reset` for 3 cycles, then release → `tx`=1, `rdata`=0, `halt`=0, STATUS read = 0x2.
- Write 0x55 to TXDATA, `CLKS_PER_BIT`=4 → `tx` low one cycle after the write edge. Line pattern is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, then `tx`=1.
- Write 0x41, 0x42, 0x43 on consecutive cycles → three back-to-back frames, decoded by the bench as "ABC". STATUS count reads 2, then 1, then 0 at successive frame starts. Each inter-frame gap is exactly 1 idle cycle.
- Write 10 bytes 0x30–0x39 in 10 consecutive cycles, `FIFO_DEPTH`=8 → the first pops in flight. Exactly one byte (0x39) is dropped, overflow=1, and 9 bytes are received. Writing 0x8 to STATUS clears overflow.
- Write 0x2A to EXIT → `halt`=1 and `exit_code`=0x2A next cycle; an EXIT read returns 0x12A. Then write 0x07 → `exit_code`=0x07 and `halt` stays 1.
- Assert `reset` 13 cycles into a 0xFF frame → `tx`=1 after that edge, FIFO empty, `halt`=0, and no further frame is sent.
